// File: rtl/saes64_ks_sequencer.sv
// saes64_ks_sequencer
// Walks an AES-128 key expansion through an external saes64 functional unit
// and emits the eleven round keys one per rk_valid pulse.
//
// The 128-bit key is kept as two 64-bit halves:
//   k0 = words 0,1 (key[63:0]) and k1 = words 2,3 (key[127:64]).
// Each round uses three FU operations:
//   ks1(k1, round) -> t, then ks2(t, k0) -> k0, then ks2(k0, k1) -> k1.
//
// Optional feature (macro SAES64_KS_DECRYPT_EN):
//   This adds the dec input and the fu_op_imix output. When dec is set at start,
//   round keys 1..9 pass through InvMixColumns (two imix ops) before they are
//   emitted. The k0/k1 chain itself is not modified.
//
// Ports
//   g_clk, g_reset      : clock, synchronous active-high reset
//   start, key          : start request (sampled in IDLE) and the cipher key
//   dec                 : (macro only) produce decryption round keys
//   busy, done          : busy from accepted start through the done pulse
//   rk_valid/rk_idx/rk  : round-key output pulse, index 0..10, key value
//   fu_valid, fu_rs1, fu_rs2, fu_enc_rcon,
//   fu_op_ks1, fu_op_ks2, fu_op_imix : FU request (held until fu_ready)
//   fu_rd, fu_ready     : FU result and completion handshake
module saes64_ks_sequencer (
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic         start,
  input  logic [127:0] key,
`ifdef SAES64_KS_DECRYPT_EN
  input  logic         dec,
  output logic         fu_op_imix,
`endif
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk,
  output logic         fu_valid,
  output logic [63:0]  fu_rs1,
  output logic [63:0]  fu_rs2,
  output logic [3:0]   fu_enc_rcon,
  output logic         fu_op_ks1,
  output logic         fu_op_ks2,
  input  logic [63:0]  fu_rd,
  input  logic         fu_ready
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_EMIT0,
    S_KS1,
    S_KS2A,
    S_KS2B,
    S_EMIT,
    S_DONE
`ifdef SAES64_KS_DECRYPT_EN
    , S_IMIXL,
    S_IMIXH
`endif
  } state_t;

  state_t      state;
  logic [63:0] k0;
  logic [63:0] k1;
  logic [3:0]  round;
`ifdef SAES64_KS_DECRYPT_EN
  logic        dec_q;
  logic [63:0] rk_lo;
`endif

  // All outputs are registered. FU request fields are loaded on the edge
  // that enters a state, so they are stable for the whole state. The ks1
  // result t is not kept separately: it is loaded straight into fu_rs1
  // for the following ks2 operation.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rk_valid    <= 1'b0;
      rk_idx      <= 4'd0;
      rk          <= 128'd0;
      round       <= 4'd0;
      k0          <= 64'd0;
      k1          <= 64'd0;
      fu_valid    <= 1'b0;
      fu_rs1      <= 64'd0;
      fu_rs2      <= 64'd0;
      fu_enc_rcon <= 4'd0;
      fu_op_ks1   <= 1'b0;
      fu_op_ks2   <= 1'b0;
`ifdef SAES64_KS_DECRYPT_EN
      fu_op_imix  <= 1'b0;
      dec_q       <= 1'b0;
      rk_lo       <= 64'd0;
`endif
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            k0       <= key[63:0];
            k1       <= key[127:64];
            round    <= 4'd0;
            busy     <= 1'b1;
            rk_valid <= 1'b1;
            rk_idx   <= 4'd0;
            rk       <= key;
`ifdef SAES64_KS_DECRYPT_EN
            dec_q    <= dec;
`endif
            state    <= S_EMIT0;
          end
        end
        S_EMIT0: begin
          fu_valid    <= 1'b1;
          fu_op_ks1   <= 1'b1;
          fu_rs1      <= k1;
          fu_rs2      <= 64'd0;
          fu_enc_rcon <= round;
          state       <= S_KS1;
        end
        S_KS1: begin
          if (fu_ready) begin
            fu_op_ks1   <= 1'b0;
            fu_op_ks2   <= 1'b1;
            fu_rs1      <= fu_rd;
            fu_rs2      <= k0;
            fu_enc_rcon <= 4'd0;
            state       <= S_KS2A;
          end
        end
        S_KS2A: begin
          if (fu_ready) begin
            k0     <= fu_rd;
            fu_rs1 <= fu_rd;
            fu_rs2 <= k1;
            state  <= S_KS2B;
          end
        end
        // The last ks2 completes the round. Decryption keys for rounds 1..9
        // take a detour through the two imix operations first.
        S_KS2B: begin
          if (fu_ready) begin
            k1 <= fu_rd;
`ifdef SAES64_KS_DECRYPT_EN
            if (dec_q && (round < 4'd9)) begin
              fu_op_ks2  <= 1'b0;
              fu_op_imix <= 1'b1;
              fu_rs1     <= k0;
              fu_rs2     <= 64'd0;
              state      <= S_IMIXL;
            end else
`endif
            begin
              fu_valid  <= 1'b0;
              fu_op_ks2 <= 1'b0;
              fu_rs1    <= 64'd0;
              fu_rs2    <= 64'd0;
              rk_valid  <= 1'b1;
              rk_idx    <= round + 4'd1;
              rk        <= {fu_rd, k0};
              state     <= S_EMIT;
            end
          end
        end
`ifdef SAES64_KS_DECRYPT_EN
        S_IMIXL: begin
          if (fu_ready) begin
            rk_lo  <= fu_rd;
            fu_rs1 <= k1;
            state  <= S_IMIXH;
          end
        end
        S_IMIXH: begin
          if (fu_ready) begin
            fu_valid   <= 1'b0;
            fu_op_imix <= 1'b0;
            fu_rs1     <= 64'd0;
            rk_valid   <= 1'b1;
            rk_idx     <= round + 4'd1;
            rk         <= {fu_rd, rk_lo};
            state      <= S_EMIT;
          end
        end
`endif
        S_EMIT: begin
          round <= round + 4'd1;
          if (round < 4'd9) begin
            fu_valid    <= 1'b1;
            fu_op_ks1   <= 1'b1;
            fu_rs1      <= k1;
            fu_rs2      <= 64'd0;
            fu_enc_rcon <= round + 4'd1;
            state       <= S_KS1;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_saes64_ks_sequencer.sv
// tb_saes64_ks_sequencer
// Self-checking bench for saes64_ks_sequencer. It provides a saes64 FU model
// (ks1/ks2/imix) that uses a random response delay. The emitted round keys are
// compared with a byte-level FIPS-197 key expansion. The bench also compares
// known vectors, start during expansion, reset in mid-expansion and, with
// SAES64_KS_DECRYPT_EN defined, decryption keys.
module tb_saes64_ks_sequencer;

  logic         g_clk = 1'b0;
  logic         g_reset;
  logic         start;
  logic [127:0] key;
  logic         busy, done, rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         fu_valid;
  logic [63:0]  fu_rs1, fu_rs2;
  logic [3:0]   fu_enc_rcon;
  logic         fu_op_ks1, fu_op_ks2;
  logic         fu_op_imix;
  logic [63:0]  fu_rd = 64'd0;
  logic         fu_ready = 1'b0;
`ifdef SAES64_KS_DECRYPT_EN
  logic         dec = 1'b0;
`else
  assign fu_op_imix = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;
  int max_delay = 0;
  int done_cnt = 0;
  logic [3:0]   got_idx[$];
  logic [127:0] got_rk[$];
  logic [127:0] ref_rk[0:10];

  saes64_ks_sequencer dut (
    .g_clk(g_clk), .g_reset(g_reset), .start(start), .key(key),
`ifdef SAES64_KS_DECRYPT_EN
    .dec(dec), .fu_op_imix(fu_op_imix),
`endif
    .busy(busy), .done(done), .rk_valid(rk_valid), .rk_idx(rk_idx), .rk(rk),
    .fu_valid(fu_valid), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2),
    .fu_enc_rcon(fu_enc_rcon), .fu_op_ks1(fu_op_ks1), .fu_op_ks2(fu_op_ks2),
    .fu_rd(fu_rd), .fu_ready(fu_ready)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // GF(2^8) helpers and AES primitives used by the FU model and the reference.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv, e;
    inv = 8'h01;
    e = 8'd254;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (e[i]) inv = gf_mul(inv, a);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, r0, r1, r2, r3;
    a0 = c[7:0]; a1 = c[15:8]; a2 = c[23:16]; a3 = c[31:24];
    r0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    r1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    r2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    r3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    return {r3, r2, r1, r0};
  endfunction

  // saes64 instruction semantics, as seen by the FU.
  function automatic logic [63:0] fu_result(input logic [63:0] rs1, input logic [63:0] rs2,
                                            input logic [3:0] rnum, input logic op1, input logic op2);
    logic [31:0] tmp, w0, w1;
    logic [7:0]  rc;
    if (op1) begin
      tmp = rs1[63:32];
      rc = 8'h00;
      if (rnum != 4'hA) begin
        tmp = {tmp[7:0], tmp[31:8]};
        rc = 8'h01;
        for (int i = 0; i < int'(rnum); i++) rc = xtime(rc);
      end
      tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {24'd0, rc};
      return {tmp, tmp};
    end else if (op2) begin
      w0 = rs1[63:32] ^ rs2[31:0];
      w1 = w0 ^ rs2[63:32];
      return {w1, w0};
    end
    return {inv_mix_col(rs1[63:32]), inv_mix_col(rs1[31:0])};
  endfunction

  // FIPS-197 key expansion over bytes: w[i] = w[i-4] ^ (SubWord(RotWord) ^ Rcon).
  task automatic ref_expand(input logic [127:0] k, input bit d);
    logic [7:0] w [0:43][0:3];
    logic [7:0] t [0:3];
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 4; b++) w[i][b] = k[8*(4*i+b) +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int b = 0; b < 4; b++) t[b] = w[i-1][b];
      if (i % 4 == 0) begin
        t[0] = sbox(w[i-1][1]) ^ rc;
        t[1] = sbox(w[i-1][2]);
        t[2] = sbox(w[i-1][3]);
        t[3] = sbox(w[i-1][0]);
        rc = xtime(rc);
      end
      for (int b = 0; b < 4; b++) w[i][b] = w[i-4][b] ^ t[b];
    end
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 4; c++)
        for (int b = 0; b < 4; b++) ref_rk[r][8*(4*c+b) +: 8] = w[4*r+c][b];
    if (d)
      for (int r = 1; r < 10; r++)
        for (int c = 0; c < 4; c++) ref_rk[r][32*c +: 32] = inv_mix_col(ref_rk[r][32*c +: 32]);
  endtask

  // FU model: this block picks a delay for each new request and checks that the
  // request is held until completion. fu_ready and fu_rd are junk while fu_valid is low.
  bit           op_active = 1'b0;
  int           op_wait = 0;
  logic [134:0] op_snap;
  always @(negedge g_clk) begin
    if (op_active && fu_ready) op_active = 1'b0;
    if (fu_valid) begin
      if (!op_active) begin
        op_active = 1'b1;
        op_wait = $urandom_range(max_delay, 0);
        op_snap = {fu_rs1, fu_rs2, fu_enc_rcon, fu_op_ks1, fu_op_ks2, fu_op_imix};
        check_output("fu_op_onehot", int'(fu_op_ks1) + int'(fu_op_ks2) + int'(fu_op_imix), 1);
        check_output("fu_rcon_range", (fu_enc_rcon <= 4'd9), 1);
      end else begin
        check_output("fu_operand_hold",
                     {fu_rs1, fu_rs2, fu_enc_rcon, fu_op_ks1, fu_op_ks2, fu_op_imix}, op_snap);
        if (op_wait > 0) op_wait--;
      end
      fu_ready = (op_wait == 0);
      fu_rd = fu_result(fu_rs1, fu_rs2, fu_enc_rcon, fu_op_ks1, fu_op_ks2);
    end else begin
      op_active = 1'b0;
      check_output("fu_op_idle", {fu_op_ks1, fu_op_ks2, fu_op_imix}, 0);
      fu_ready = 1'($urandom_range(1, 0));
      fu_rd = {$urandom, $urandom};
    end
  end

  always @(negedge g_clk) begin
    if (rk_valid) begin
      got_idx.push_back(rk_idx);
      got_rk.push_back(rk);
      check_output("busy_with_rk_valid", busy, 1);
    end
    if (done) begin
      done_cnt++;
      check_output("busy_with_done", busy, 1);
    end
  end

  task automatic clear_capture();
    got_idx.delete();
    got_rk.delete();
    done_cnt = 0;
  endtask

  // This task starts one expansion and waits for done. If poke is non-zero,
  // start is pulsed again with a different key poke cycles into the run.
  task automatic apply_stimulus(input logic [127:0] k, input bit d, input int poke);
    clear_capture();
    key = k;
    start = 1'b1;
`ifdef SAES64_KS_DECRYPT_EN
    dec = d;
`endif
    @(negedge g_clk);
    start = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    check_output("busy_after_start", busy, 1);
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      if (poke != 0 && c == poke) start = 1'b1;
      if (poke != 0 && c == poke + 4) start = 1'b0;
      @(negedge g_clk);
    end
    start = 1'b0;
    if (done_cnt == 0) check_output("done_timeout", 0, 1);
    repeat (6) @(negedge g_clk);
    check_output("busy_after_done", busy, 0);
  endtask

  task automatic check_run(input logic [127:0] k, input bit d, input string tag);
    ref_expand(k, d);
    check_output($sformatf("%s_pulses", tag), got_idx.size(), 11);
    for (int i = 0; i < 11; i++) begin
      if (i < got_idx.size()) begin
        check_output($sformatf("%s_idx%0d", tag, i), got_idx[i], i);
        check_output($sformatf("%s_rk%0d", tag, i), got_rk[i], ref_rk[i]);
      end
    end
    check_output($sformatf("%s_done_count", tag), done_cnt, 1);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] exp1;
    logic [127:0] exp10;
    int           delay;
  } vec_t;

  vec_t vecs[3];
  logic [127:0] k_rand;
  bit           found;
  int           n_before;

  initial begin
    // Byte-0-first notation (the leftmost byte is byte 0).
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5, 5};
    vecs[2] = '{128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e, 2};

    g_reset = 1'b1;
    start = 1'b0;
    key = '0;
    repeat (2) @(negedge g_clk);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_rk_valid", rk_valid, 0);
    check_output("reset_fu_valid", fu_valid, 0);
    check_output("reset_fu_ops", {fu_op_ks1, fu_op_ks2, fu_op_imix}, 0);
    check_output("reset_rk_idx", rk_idx, 0);
    check_output("reset_rk", rk, 0);

    // When reset and start are both high in the same cycle, reset wins.
    start = 1'b1;
    key = bswap(vecs[0].key);
    @(negedge g_clk);
    check_output("reset_over_start_busy", busy, 0);
    check_output("reset_over_start_rk_valid", rk_valid, 0);
    start = 1'b0;
    g_reset = 1'b0;
    @(negedge g_clk);

    for (int v = 0; v < 3; v++) begin
      max_delay = vecs[v].delay;
      apply_stimulus(bswap(vecs[v].key), 1'b0, 0);
      check_run(bswap(vecs[v].key), 1'b0, $sformatf("vec%0d", v));
      if (got_rk.size() == 11) begin
        check_output($sformatf("vec%0d_known_rk1", v), got_rk[1], bswap(vecs[v].exp1));
        check_output($sformatf("vec%0d_known_rk10", v), got_rk[10], bswap(vecs[v].exp10));
      end
    end

    for (int n = 0; n < 4; n++) begin
      max_delay = 5;
      k_rand = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(k_rand, 1'b0, 0);
      check_run(k_rand, 1'b0, $sformatf("rand%0d", n));
    end

    // Start is raised again during the expansion. The expansion must not restart.
    max_delay = 0;
    k_rand = {$urandom, $urandom, $urandom, $urandom};
    apply_stimulus(k_rand, 1'b0, 10);
    check_run(k_rand, 1'b0, "restart");

    // Reset is applied while the sequencer is in KS2A of round 5.
    max_delay = 3;
    clear_capture();
    k_rand = {$urandom, $urandom, $urandom, $urandom};
    key = k_rand;
    start = 1'b1;
    @(negedge g_clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge g_clk);
      if (got_idx.size() >= 6 && fu_valid && fu_op_ks2) found = 1'b1;
    end
    check_output("midreset_reach_ks2a", found, 1);
    g_reset = 1'b1;
    @(negedge g_clk);
    check_output("midreset_fu_valid", fu_valid, 0);
    check_output("midreset_busy", busy, 0);
    check_output("midreset_rk_valid", rk_valid, 0);
    g_reset = 1'b0;
    n_before = got_idx.size();
    repeat (20) @(negedge g_clk);
    check_output("midreset_no_more_rk", got_idx.size(), n_before);
    check_output("midreset_pulses_seen", n_before, 6);
    check_output("midreset_no_done", done_cnt, 0);
    apply_stimulus(k_rand, 1'b0, 0);
    check_run(k_rand, 1'b0, "after_reset");

`ifdef SAES64_KS_DECRYPT_EN
    max_delay = 0;
    apply_stimulus(bswap(vecs[0].key), 1'b1, 0);
    check_run(bswap(vecs[0].key), 1'b1, "dec_fips");
    max_delay = 4;
    k_rand = {$urandom, $urandom, $urandom, $urandom};
    apply_stimulus(k_rand, 1'b1, 0);
    check_run(k_rand, 1'b1, "dec_rand");
    apply_stimulus(k_rand, 1'b0, 0);
    check_run(k_rand, 1'b0, "enc_after_dec");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
